video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameters H_FP 110, H_SYNC 40, H_BP 220: front porch, sync and back porch widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE 720, V_FP 5, V_SYNC 5, V_BP 20: active lines and porch/sync widths in lines.
REQ-004 SHALL have parameters HSYNC_POL 1 and VSYNC_POL 1, the asserted sync levels.
REQ-005 SHALL have port video_clock, input, 1 bit, the pixel clock and only clock.
REQ-006 SHALL have port reset_n, input, 1 bit; reset is synchronous and active-low.
REQ-007 SHALL have port enable, input, 1 bit, requesting frame generation.
REQ-008 SHALL have port pattern_en, input, 1 bit, selecting the internal test pattern.
REQ-009 SHALL have ports pix_data (input, 24 bits, {R,G,B}) and pix_valid (input, 1 bit), the upstream pixel stream.
REQ-010 SHALL have port pix_ready, output, 1 bit, pixel accept strobe.
REQ-011 SHALL have ports video_hsync, video_vsync and video_de (outputs, 1 bit each) and video_data (output, 24 bits), feeding the TMDS transmitter.
REQ-012 SHALL have ports frame_start (output, 1 bit), a pulse on the first pixel of each frame, and underflow (output, 1 bit), a missing-pixel pulse.

Function
REQ-013 SHALL keep counters h_cnt (12 bits, 0..HT-1, HT = H_ACTIVE+H_FP+H_SYNC+H_BP) and v_cnt (11 bits, 0..VT-1, VT = sum of the V parameters); h_cnt wraps to 0 at HT-1 and increments v_cnt, and v_cnt wraps to 0 at VT-1.
REQ-014 SHALL implement FSM IDLE/RUN/STOPPING; in IDLE, counters are held at 0.
REQ-015 SHALL move IDLE->RUN when enable=1 is sampled; counting starts from h_cnt=0, v_cnt=0 on the next cycle.
REQ-016 SHALL move RUN->STOPPING when enable=0 is sampled, and STOPPING->IDLE after h_cnt=HT-1, v_cnt=VT-1 completes; enable=1 in STOPPING returns to RUN with no gap in counting.
REQ-017 SHALL drive pix_ready combinationally high when in RUN or STOPPING with h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, and with pattern generation not active.
REQ-018 SHALL register all video outputs with 1 cycle latency from counter position to outputs.
REQ-019 SHALL assert video_hsync for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
REQ-020 SHALL assert video_vsync for whole lines with v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), with edges at h_cnt=0.
REQ-021 SHALL drive video_de=1 exactly on active positions, independent of pix_valid.
REQ-022 SHALL output video_data=pix_data when an active slot sees pix_valid=1; with pix_valid=0 in an active slot, video_data=24'h000000 and underflow pulses together with video_de.
REQ-023 SHALL set video_data=0 whenever video_de=0.
REQ-024 SHALL pulse frame_start together with the video_de of position (0,0).
REQ-025 SHALL produce sync outputs at the deasserted level (~POL) while in IDLE.
REQ-026 SHALL constrain parameters so that HT<=4095 and VT<=2047; a violation is an elaboration error.

Reset
REQ-027 SHALL, when reset_n=0 at a clock edge, set the FSM to IDLE, both counters to 0, video_de=0, video_data=0, frame_start=0, underflow=0, and syncs to ~POL.
REQ-028 SHALL abort the frame when reset occurs mid-frame; outputs reach reset values at that same edge, and a restart requires enable.

Configuration
REQ-029 SHALL with macro VIDEO_TIMING_GEN_TEST_PATTERN_EN defined and pattern_en=1: generate 8 vertical bars, each H_ACTIVE/8 wide, in the order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; hold pix_ready=0; never pulse underflow.
REQ-030 SHALL without that macro ignore pattern_en, and include no pattern logic.

Verification
REQ-031 SHALL check default parameters with enable=1 and pix_valid=1: frame period 1237500 cycles; hsync high for h_cnt 1390..1429; vsync high for lines 725..729; 921600 de cycles per frame.
REQ-032 SHALL check that holding pix_valid=0 for 3 active cycles gives 3 underflow pulses with video_data=0, and that de timing is unchanged.
REQ-033 SHALL check that dropping enable mid-frame completes the frame, then goes IDLE; re-raising enable during STOPPING gives a continuous next frame_start exactly 1237500 cycles after the previous one.
REQ-034 SHALL check that reset_n=0 for 1 cycle at line 300 forces de=0 and sync low on that edge, with no output until enable is re-sampled.
REQ-035 SHALL check, with the macro defined and pattern_en=1, that pixel 0 gives FFFFFF, pixel 160 gives FFFF00, pixel 1279 gives 000000, and pix_ready stays 0.
REQ-036 SHALL check, with H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4 and V_FP=V_SYNC=V_BP=1, the h and v wrap points and a frame_start pulse every 98 cycles.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, syncs, DE and pixel muxing for a TMDS transmitter.
// Optional colour-bar source is built only with VIDEO_TIMING_GEN_TEST_PATTERN_EN.
module video_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        video_clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pattern_en,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic        video_de,
  output logic [23:0] video_data,
  output logic        frame_start,
  output logic        underflow
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (HT > 4095 || VT > 2047) begin : g_bad_timing
      $error("video_timing_gen: HT must be <= 4095 and VT <= 2047");
    end
  endgenerate

  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST = 12'(HT - 1);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST = 11'(VT - 1);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [10:0] v_q, v_d;

  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [23:0] data_q, data_d;
  logic        fs_q, fs_d;
  logic        uf_q, uf_d;

  logic        running;
  logic        h_end;
  logic        v_end;
  logic        active;
  logic        pat_act;
  logic [23:0] bar_rgb;

  assign running = (state_q != S_IDLE);
  assign h_end   = (h_q == H_LAST);
  assign v_end   = (v_q == V_LAST);
  assign active  = (h_q < H_ACT) && (v_q < V_ACT);

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [2:0] bar;

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_q >= 12'(k * BAR_W)) bar = 3'(k);
    end
  end

  // Bar order W,Y,C,G,M,R,B,K maps to R=~b1, G=~b2, B=~b0
  assign bar_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  assign pat_act = pattern_en;
`else
  logic unused_pattern_en;

  assign unused_pattern_en = pattern_en;
  assign bar_rgb = '0;
  assign pat_act = 1'b0;
`endif

  assign pix_ready = running && active && !pat_act;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable) state_d = S_STOP;
      end
      S_STOP: begin
        if (enable) state_d = S_RUN;
        else if (h_end && v_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!running) begin
      h_d = '0;
      v_d = '0;
    end else if (h_end) begin
      h_d = '0;
      v_d = v_end ? '0 : v_q + 11'd1;
    end else begin
      h_d = h_q + 12'd1;
    end
  end

  always_comb begin
    de_d   = running && active;
    hs_d   = ~HSYNC_POL;
    vs_d   = ~VSYNC_POL;
    data_d = '0;
    uf_d   = 1'b0;
    fs_d   = de_d && (h_q == '0) && (v_q == '0);
    if (running && h_q >= HS_BEG && h_q < HS_END) hs_d = HSYNC_POL;
    if (running && v_q >= VS_BEG && v_q < VS_END) vs_d = VSYNC_POL;
    if (de_d) begin
      if (pat_act) begin
        data_d = bar_rgb;
      end else if (pix_valid) begin
        data_d = pix_data;
      end else begin
        uf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge video_clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HSYNC_POL;
      vs_q    <= ~VSYNC_POL;
      data_q  <= '0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      data_q  <= data_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  assign video_de    = de_q;
  assign video_hsync = hs_q;
  assign video_vsync = vs_q;
  assign video_data  = data_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a tiny 14x7 raster against a
// frame-position reference model.
module tb_video_timing_gen;

  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HS  = 2;
  localparam int HB  = 2;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VS  = 1;
  localparam int VB  = 1;
  localparam int HT  = HA + HFP + HS + HB;
  localparam int VT  = VA + VFP + VS + VB;
  localparam int FT  = HT * VT;

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  localparam bit PAT_BUILD = 1'b1;
`else
  localparam bit PAT_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        pattern_en;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        video_hsync;
  logic        video_vsync;
  logic        video_de;
  logic [23:0] video_data;
  logic        frame_start;
  logic        underflow;

  video_timing_gen #(
    .H_ACTIVE (HA),
    .H_FP     (HFP),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VS),
    .V_BP     (VB)
  ) dut (
    .video_clock (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .pattern_en  (pattern_en),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .video_hsync (video_hsync),
    .video_vsync (video_vsync),
    .video_de    (video_de),
    .video_data  (video_data),
    .frame_start (frame_start),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: pos = linear raster index presented this cycle, -1 = idle
  int pos = -1;
  bit stopping = 1'b0;

  int  cyc = 0;
  int  prev_fs = 0;
  bit  have_prev = 1'b0;
  bit  chk_period = 1'b0;
  int  de_acc = 0;
  int  de_win = 0;
  int  fs_win = 0;
  int  uf_acc = 0;
  int  drop_left = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [23:0] bar_color(input int h);
    logic [23:0] t [8];
    int i;
    t = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    i = h / (HA / 8);
    if (i > 7) i = 7;
    return t[i];
  endfunction

  task automatic step(input bit en, input bit pv, input bit pe,
                      input bit rst);
    logic [23:0] d;
    int h, v;
    bit act, pat, rdy;
    bit e_de, e_hs, e_vs, e_fs, e_uf;
    logic [23:0] e_data;
    @(negedge clk);
    d = 24'($urandom);
    pat = PAT_BUILD && pe;
    h = (pos >= 0) ? pos % HT : 0;
    v = (pos >= 0) ? pos / HT : 0;
    act = (pos >= 0) && h < HA && v < VA;
    rdy = act && !pat;
    if (drop_left > 0 && rdy) begin
      pv = 1'b0;
      drop_left--;
    end
    enable = en;
    pix_valid = pv;
    pix_data = d;
    pattern_en = pe;
    reset_n = rst;
    #1;
    chk("pix_ready", pix_ready, rdy);
    e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_uf = 0; e_data = '0;
    if (rst && pos >= 0) begin
      e_de = act;
      e_hs = h >= HA + HFP && h < HA + HFP + HS;
      e_vs = v >= VA + VFP && v < VA + VFP + VS;
      e_fs = (pos == 0);
      e_uf = act && !pv && !pat;
      if (act) e_data = pat ? bar_color(h) : (pv ? d : 24'h0);
    end
    if (!rst) begin
      pos = -1;
      stopping = 0;
    end else if (pos < 0) begin
      if (en) begin
        pos = 0;
        stopping = 0;
      end
    end else if (stopping) begin
      if (en) begin
        stopping = 0;
        pos = (pos + 1) % FT;
      end else if (pos == FT - 1) begin
        pos = -1;
      end else begin
        pos++;
      end
    end else begin
      if (!en) stopping = 1;
      pos = (pos + 1) % FT;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("video_de", video_de, e_de);
    chk("video_hsync", video_hsync, e_hs);
    chk("video_vsync", video_vsync, e_vs);
    chk("video_data", video_data, e_data);
    chk("frame_start", frame_start, e_fs);
    chk("underflow", underflow, e_uf);
    if (frame_start === 1'b1) begin
      if (chk_period && have_prev) begin
        chk("fs_period", cyc - prev_fs, FT);
        chk("de_per_frame", de_acc, HA * VA);
      end
      have_prev = 1;
      prev_fs = cyc;
      de_acc = 0;
      fs_win++;
    end
    if (video_de === 1'b1) begin
      de_acc++;
      de_win++;
    end
    if (underflow === 1'b1) uf_acc++;
    if (pos < 0) have_prev = 0;
  endtask

  initial begin
    bit en, pv, pe, rst, hit;
    reset_n = 1'b0;
    enable = 1'b0;
    pattern_en = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 1);

    chk_period = 1;
    for (int i = 0; i < 300; i++) step(1, 1, 0, 1);

    drop_left = 3;
    uf_acc = 0;
    for (int i = 0; i < 110; i++) step(1, 1, 0, 1);
    chk("uf_pulses", uf_acc, 3);

    hit = 0;
    for (int i = 0; i < 120 && !hit; i++) begin
      step(1, 1, 0, 1);
      hit = (pos == 40);
    end
    chk("reach_pos40", hit, 1);
    fs_win = 0;
    for (int i = 0; i < 120; i++) step(0, 1, 0, 1);
    de_win = 0;
    for (int i = 0; i < 80; i++) step(0, 1, 0, 1);
    chk("fs_after_stop", fs_win, 0);
    chk("de_while_idle", de_win, 0);

    fs_win = 0;
    for (int i = 0; i < 30; i++) step(1, 1, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 1);
    for (int i = 0; i < 250; i++) step(1, 1, 0, 1);
    chk("fs_continuous", fs_win, 4);

    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step(1, 1, 0, 1);
      hit = (pos == 2 * HT + 3);
    end
    chk("reach_line2", hit, 1);
    step(1, 1, 0, 0);
    chk("rst_abort_de", video_de, 0);
    chk("rst_abort_hs", video_hsync, 0);
    fs_win = 0;
    de_win = 0;
    for (int i = 0; i < 20; i++) step(0, 1, 0, 1);
    chk("no_out_after_rst", de_win, 0);
    for (int i = 0; i < 100; i++) step(1, 1, 0, 1);

    chk_period = 0;
    en = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) en = !en;
      pv = ($urandom_range(0, 6) != 0);
      pe = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) != 0);
      step(en, pv, pe, rst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
